alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_alu_cmd_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the ALU command sequencer and its register file.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MOV  = 4'h2,
    OP_SBB  = 4'h3,
    OP_INC  = 4'h4,
    OP_DEC  = 4'h5,
    OP_ADDI = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_NOT  = 4'hA,
    OP_SHL  = 4'hB
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_LAST = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } seq_state_e;

  // Codes above OP_LAST are rejected by the sequencer.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async operand read ports, async host read port,
// one synchronous write port and synchronous clear.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     a_addr,
  input  logic [AW-1:0]     b_addr,
  input  logic [AW-1:0]     host_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] host_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Clear wins over a pending write so an interrupted command leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign a_data    = regs[a_addr];
  assign b_data    = regs[b_addr];
  assign host_data = regs[host_addr];

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: IDLE -> ISSUE -> WB around an external combinational ALU.
// Optional flag_z/flag_n outputs are enabled by defining ALU_CMD_SEQ_FLAGS_EN.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  output logic [OP_W-1:0]   alu_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
`ifdef ALU_CMD_SEQ_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  input  logic [AW-1:0]     host_addr,
  output logic [DATA_W-1:0] host_data
);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              ready_d, wb_valid_d, err_d;
  logic [OP_W-1:0]   alu_s_d;
  logic [DATA_W-1:0] alu_a_d, alu_b_d;
  logic [AW-1:0]     wb_rd_d;
  logic [DATA_W-1:0] wb_data_d;
  logic [DATA_W-1:0] a_data, b_data;
  logic              we_c;

  // Write happens at the end of WB, so a command accepted next cycle sees it.
  assign we_c = (state_q == ST_WB);

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we_c),
    .wa        (wb_rd),
    .wd        (wb_data),
    .a_addr    (cmd_ra),
    .b_addr    (cmd_rb),
    .host_addr (host_addr),
    .a_data    (a_data),
    .b_data    (b_data),
    .host_data (host_data)
  );

  // Next-state and next-output logic; ALU drive is zero except while in ISSUE.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    alu_s_d    = '0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (op_legal(cmd_op)) begin
            state_d = ST_ISSUE;
            rd_d    = cmd_rd;
            alu_s_d = cmd_op;
            alu_a_d = a_data;
            alu_b_d = b_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d    = ST_WB;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = alu_result;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      cmd_ready <= 1'b0;
      wb_valid  <= 1'b0;
      err       <= 1'b0;
      alu_s     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      cmd_ready <= ready_d;
      wb_valid  <= wb_valid_d;
      err       <= err_d;
      alu_s     <= alu_s_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
    end
  end

`ifdef ALU_CMD_SEQ_FLAGS_EN
  logic flag_z_d, flag_n_d;

  // Flags track the value being written back and hold between writes.
  always_comb begin
    flag_z_d = flag_z;
    flag_n_d = flag_n;
    if (state_q == ST_ISSUE) begin
      flag_z_d = (alu_result == '0);
      flag_n_d = alu_result[DATA_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      flag_z <= flag_z_d;
      flag_n <= flag_n_d;
    end
  end
`else
  // Flags disabled: no flag ports or state exist in this build.
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq with a bench-side ALU and register model.
// Flag checks are compiled in when ALU_CMD_SEQ_FLAGS_EN is defined.
module tb_alu_cmd_seq;
  import alu_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_ra, cmd_rb;
  logic [3:0]    alu_s;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          err;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
`ifdef ALU_CMD_SEQ_FLAGS_EN
  logic          flag_z, flag_n;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mregs [NR];
  logic [AW-1:0] q_rd [$];
  logic [DW-1:0] q_data [$];
  logic [DW-1:0] acc_a, acc_b, old_v, exp_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_seq #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .alu_s      (alu_s),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .err        (err),
`ifdef ALU_CMD_SEQ_FLAGS_EN
    .flag_z     (flag_z),
    .flag_n     (flag_n),
`endif
    .host_addr  (host_addr),
    .host_data  (host_data)
  );

  // External ALU stand-in.
  function automatic logic [DW-1:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    case (op)
      4'h0: return DW'(a + b);
      4'h1: return DW'(a - b);
      4'h2: return a;
      4'h3: return DW'(a - b - DW'(1));
      4'h4: return DW'(a + DW'(1));
      4'h5: return DW'(a - DW'(1));
      4'h6: return DW'(a + b);
      4'h7: return a & b;
      4'h8: return a | b;
      4'h9: return a ^ b;
      4'hA: return ~a;
      4'hB: return DW'(a << 1);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_s, alu_a, alu_b);

  // Scoreboard: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      total++;
      if (q_data.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got wb_rd=%0d wb_data=%h want no write-back", wb_rd, wb_data);
      end else begin
        logic [AW-1:0] er;
        logic [DW-1:0] ed;
        er = q_rd.pop_front();
        ed = q_data.pop_front();
        if (wb_rd !== er || wb_data !== ed) begin
          bad++;
          $display("FAIL wb_payload: got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, er, ed);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Offer one command and return just after the accepting edge.
  task automatic do_cmd(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input bit track);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: got cmd_ready=%b want 1", cmd_ready);
    end
    acc_a = mregs[ra];
    acc_b = mregs[rb];
    old_v = mregs[rd];
    exp_v = alu_model(op, acc_a, acc_b);
    if (track && op <= OP_LAST) begin
      q_rd.push_back(rd);
      q_data.push_back(exp_v);
      mregs[rd] = exp_v;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Legal command with full cycle-by-cycle checking of ISSUE, WB and return to IDLE.
  task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb);
    do_cmd(op, rd, ra, rb, 1'b1);
    @(negedge clk);
    total++;
    if (alu_s !== op || alu_a !== acc_a || alu_b !== acc_b || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL issue_drive: got s=%h a=%h b=%h wbv=%b want s=%h a=%h b=%h wbv=0",
               alu_s, alu_a, alu_b, wb_valid, op, acc_a, acc_b);
    end
    @(negedge clk);
    host_addr = rd;
    #1;
    total++;
    if (wb_valid !== 1'b1 || host_data !== old_v || alu_s !== 4'h0) begin
      bad++;
      $display("FAIL wb_cycle: got wbv=%b host=%h s=%h want wbv=1 host=%h s=0",
               wb_valid, host_data, alu_s, old_v);
    end
    @(negedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1 || host_data !== exp_v || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_wb: got rdy=%b host=%h wbv=%b want rdy=1 host=%h wbv=0",
               cmd_ready, host_data, wb_valid, exp_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    host_addr = '0;
    for (int i = 0; i < int'(NR); i++) mregs[i] = '0;
    repeat (3) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || alu_s !== 4'h0 ||
        alu_a !== '0 || alu_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b wbv=%b err=%b s=%h a=%h b=%h want all 0",
               cmd_ready, wb_valid, err, alu_s, alu_a, alu_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
    for (int i = 0; i < int'(NR); i++) begin
      host_addr = AW'(i);
      #1;
      total++;
      if (host_data !== '0) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want 0000", i, host_data);
      end
    end
  endtask

  task automatic test_add;
    for (int i = 0; i < 5; i++) run_cmd(OP_INC, 3'd1, 3'd1, 3'd0);
    for (int i = 0; i < 3; i++) run_cmd(OP_INC, 3'd2, 3'd2, 3'd0);
    run_cmd(OP_ADD, 3'd3, 3'd1, 3'd2);
    host_addr = 3'd3;
    #1;
    total++;
    if (host_data !== 16'd8) begin
      bad++;
      $display("FAIL add_r3: got %h want 0008", host_data);
    end
  endtask

  task automatic test_sub_flags;
    run_cmd(OP_SUB, 3'd4, 3'd2, 3'd1);
    host_addr = 3'd4;
    #1;
    total++;
    if (host_data !== 16'hFFFE) begin
      bad++;
      $display("FAIL sub_r4: got %h want fffe", host_data);
    end
`ifdef ALU_CMD_SEQ_FLAGS_EN
    total++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0) begin
      bad++;
      $display("FAIL sub_flags: got n=%b z=%b want n=1 z=0", flag_n, flag_z);
    end
`endif
    run_cmd(OP_XOR, 3'd5, 3'd1, 3'd1);
`ifdef ALU_CMD_SEQ_FLAGS_EN
    total++;
    if (flag_n !== 1'b0 || flag_z !== 1'b1) begin
      bad++;
      $display("FAIL zero_flags: got n=%b z=%b want n=0 z=1", flag_n, flag_z);
    end
`endif
  endtask

  task automatic test_boundaries;
    run_cmd(OP_ADD, 3'd2, 3'd2, 3'd2);
    run_cmd(OP_ADD, 3'd6, 3'd4, 3'd2);
    host_addr = 3'd6;
    #1;
    total++;
    if (host_data !== 16'h0004) begin
      bad++;
      $display("FAIL truncate_r6: got %h want 0004", host_data);
    end
    run_cmd(OP_SHL, 3'd7, 3'd4, 3'd0);
  endtask

  task automatic test_err(input logic [3:0] op);
    do_cmd(op, 3'd3, 3'd1, 3'd2, 1'b0);
    @(negedge clk);
    total++;
    if (err !== 1'b1 || wb_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_s !== 4'h0) begin
      bad++;
      $display("FAIL err_pulse op=%h: got err=%b wbv=%b rdy=%b s=%h want err=1 wbv=0 rdy=1 s=0",
               op, err, wb_valid, cmd_ready, alu_s);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_once op=%h: got err=%b wbv=%b want 0 0", op, err, wb_valid);
    end
    for (int i = 0; i < int'(NR); i++) begin
      host_addr = AW'(i);
      #1;
      total++;
      if (host_data !== mregs[i]) begin
        bad++;
        $display("FAIL err_regs r%0d: got %h want %h", i, host_data, mregs[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc [3];
    logic [3:0]    ops [3];
    logic [AW-1:0] rds [3];
    logic [AW-1:0] ras [3];
    logic [AW-1:0] rbs [3];
    int n;
    ops[0] = OP_ADD; rds[0] = 3'd5; ras[0] = 3'd1; rbs[0] = 3'd2;
    ops[1] = OP_ADD; rds[1] = 3'd6; ras[1] = 3'd5; rbs[1] = 3'd5;
    ops[2] = OP_SUB; rds[2] = 3'd7; ras[2] = 3'd6; rbs[2] = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_op = ops[k]; cmd_rd = rds[k]; cmd_ra = ras[k]; cmd_rb = rbs[k];
      n = 0;
      while (cmd_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready%0d: got %b want 1", k, cmd_ready);
      end
      acc_cyc[k] = cyc;
      exp_v = alu_model(ops[k], mregs[ras[k]], mregs[rbs[k]]);
      q_rd.push_back(rds[k]);
      q_data.push_back(exp_v);
      mregs[rds[k]] = exp_v;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 1; k < 3; k++) begin
      total++;
      if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
        bad++;
        $display("FAIL b2b_spacing%0d: got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    host_addr = 3'd6;
    #1;
    total++;
    if (host_data !== 16'd22) begin
      bad++;
      $display("FAIL b2b_r6: got %h want 0016", host_data);
    end
  endtask

  task automatic test_reset_mid;
    do_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0 || alu_s !== 4'h0 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got wbv=%b s=%h rdy=%b want 0 0 0", wb_valid, alu_s, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(NR); i++) mregs[i] = '0;
    @(negedge clk);
    host_addr = 3'd3;
    #1;
    total++;
    if (host_data !== '0 || cmd_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_after: got r3=%h rdy=%b wbv=%b want 0000 1 0",
               host_data, cmd_ready, wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_flags();
    test_boundaries();
    test_err(4'hE);
    test_err(4'hC);
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++;
    if (q_data.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q_data.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
